// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-byte holding register handshake between UART receiver and consumer
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_byte, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_byte, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with optional parity, 1/2 stop bits, held-byte handshake
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_serial,
    input  logic             i_bd,
    output logic             o_busy,
    uart_rx_param_if.master  rx
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);
    localparam logic             ODD_PAR   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic [1:0]           sync;
    logic                 line;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_perr, frame_ferr, ferr_final;
    logic                 armed;
    logic                 mid_start, mid_bit, handshake;
    logic                 cnt_clr, cnt_inc, idx_clr, idx_inc;
    logic                 shift_en, frame_clr, par_smp, stop_smp, complete;

    assign line      = sync[1];
    assign mid_start = i_bd && (cnt == HALF_LAST);
    assign mid_bit   = i_bd && (cnt == BIT_LAST);
    assign handshake = rx.rx_valid && rx.rx_ready;
    assign ferr_final = frame_ferr || (stop_smp && !line);

    always_ff @(posedge i_clk) begin
        if (i_reset) sync <= 2'b11;
        else         sync <= {sync[0], i_rx_serial};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (armed && !line) state_nx = START;
            START:  if (mid_start) state_nx = line ? IDLE : DATA;
            DATA:   if (mid_bit && idx == DATA_LAST) state_nx = HAS_PAR ? PARITY : STOP;
            PARITY: if (mid_bit) state_nx = STOP;
            STOP:   if (mid_bit && idx == STOP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        shift_en  = 1'b0;
        frame_clr = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        complete  = 1'b0;
        o_busy    = (state != IDLE);
        case (state)
            IDLE: cnt_clr = 1'b1;
            START: begin
                if (mid_start) begin
                    cnt_clr   = 1'b1;
                    idx_clr   = 1'b1;
                    frame_clr = 1'b1;
                end else if (i_bd) begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (idx == DATA_LAST) idx_clr = 1'b1;
                    else                  idx_inc = 1'b1;
                end else if (i_bd) begin
                    cnt_inc = 1'b1;
                end
            end
            PARITY: begin
                if (mid_bit) begin
                    par_smp = 1'b1;
                    cnt_clr = 1'b1;
                end else if (i_bd) begin
                    cnt_inc = 1'b1;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    stop_smp = 1'b1;
                    cnt_clr  = 1'b1;
                    if (idx == STOP_LAST) complete = 1'b1;
                    else                  idx_inc  = 1'b1;
                end else if (i_bd) begin
                    cnt_inc = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            frame_perr <= 1'b0;
            frame_ferr <= 1'b0;
            armed      <= 1'b1;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (shift_en) shreg <= {line, shreg[DATA_BITS-1:1]};
            if (frame_clr) begin
                frame_perr <= 1'b0;
                frame_ferr <= 1'b0;
            end
            if (par_smp) frame_perr <= line ^ (^shreg) ^ ODD_PAR;
            if (stop_smp && !line) frame_ferr <= 1'b1;
            // A broken stop bit keeps the receiver deaf until the line is seen idle, so a break cannot retrigger it
            if (complete && ferr_final) armed <= 1'b0;
            else if (i_bd && line)      armed <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx.rx_byte    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.overrun    <= 1'b0;
        end else begin
            if (complete && (!rx.rx_valid || handshake)) begin
                rx.rx_byte    <= shreg;
                rx.parity_err <= HAS_PAR && frame_perr;
                rx.frame_err  <= ferr_final;
                rx.rx_valid   <= 1'b1;
            end else if (handshake) begin
                rx.rx_valid <= 1'b0;
            end
            if (handshake) rx.overrun <= 1'b0;
            else if (complete && rx.rx_valid) rx.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed and randomized checks of uart_rx_param against a frame-level model
module tb_uart_rx_param;
    localparam int BD_DIV = 4;
    localparam int OS0 = 16;
    localparam int OS1 = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser0 = 1'b1;
    logic ser1 = 1'b1;
    logic bd = 1'b0;
    logic busy0, busy1;
    int   div = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   sb_en = 1'b0;
    bit   busy_seen = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();

    uart_rx_param dut0 (
        .i_clk(clk), .i_reset(reset), .i_rx_serial(ser0), .i_bd(bd), .o_busy(busy0), .rx(if0)
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(OS1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut1 (
        .i_clk(clk), .i_reset(reset), .i_rx_serial(ser1), .i_bd(bd), .o_busy(busy1), .rx(if1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = (div + 1) % BD_DIV;
        bd  = (div == 0);
        if (busy0) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (bd !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send(input int which, input logic [15:0] bits, input int n, input int os);
        for (int i = 0; i < n; i++) begin
            if (which == 0) ser0 = bits[i];
            else            ser1 = bits[i];
            wait_ticks(os);
        end
    endtask

    function automatic logic [15:0] frame0(input logic [7:0] d, input logic stp);
        return {6'b0, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame1(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        return {4'b0, s2, s1, p, d, 1'b0};
    endfunction

    task automatic wait_valid(input int which, input string tag);
        int k = 0;
        while (((which == 0) ? if0.rx_valid : if1.rx_valid) !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) check(tag, 32'd0, 32'd1);
    endtask

    task automatic consume(input int which);
        if (which == 0) if0.rx_ready = 1'b1;
        else            if1.rx_ready = 1'b1;
        @(negedge clk);
        if0.rx_ready = 1'b0;
        if1.rx_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_en && if0.rx_valid && if0.rx_ready) begin
            if (q0.size() == 0) check("sb0_extra", 32'd1, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("sb0_byte", if0.rx_byte, e0.d);
                check("sb0_perr", if0.parity_err, e0.pe);
                check("sb0_ferr", if0.frame_err, e0.fe);
            end
        end
        if (sb_en && if1.rx_valid && if1.rx_ready) begin
            if (q1.size() == 0) check("sb1_extra", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("sb1_byte", if1.rx_byte, e1.d);
                check("sb1_perr", if1.parity_err, e1.pe);
                check("sb1_ferr", if1.frame_err, e1.fe);
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       p, s1, s2, stp;

        if0.rx_ready = 1'b0;
        if1.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", if0.rx_valid, 0);
        check("rst_byte", if0.rx_byte, 0);
        check("rst_perr", if0.parity_err, 0);
        check("rst_ferr", if0.frame_err, 0);
        check("rst_ovr", if0.overrun, 0);
        check("rst_busy", busy0, 0);
        check("rst_valid1", if1.rx_valid, 0);
        check("rst_busy1", busy1, 0);
        reset = 1'b0;
        wait_ticks(4);

        send(0, frame0(8'hA5, 1'b1), 10, OS0);
        wait_valid(0, "a5_timeout");
        check("a5_byte", if0.rx_byte, 8'hA5);
        check("a5_perr", if0.parity_err, 0);
        check("a5_ferr", if0.frame_err, 0);
        repeat (50) @(negedge clk);
        check("a5_hold_valid", if0.rx_valid, 1);
        check("a5_hold_byte", if0.rx_byte, 8'hA5);
        consume(0);
        check("a5_consumed", if0.rx_valid, 0);

        send(1, frame1(8'h07, 1'b0, 1'b1, 1'b1), 12, OS1);
        wait_valid(1, "par0_timeout");
        check("par0_byte", if1.rx_byte, 8'h07);
        check("par0_perr", if1.parity_err, 1);
        check("par0_ferr", if1.frame_err, 0);
        consume(1);
        send(1, frame1(8'h07, 1'b1, 1'b1, 1'b1), 12, OS1);
        wait_valid(1, "par1_timeout");
        check("par1_byte", if1.rx_byte, 8'h07);
        check("par1_perr", if1.parity_err, 0);
        consume(1);

        ser0 = 1'b0;
        wait_ticks(2);
        check("fs_busy", busy0, 1);
        wait_ticks(2);
        ser0 = 1'b1;
        wait_ticks(10);
        check("fs_idle", busy0, 0);
        check("fs_valid", if0.rx_valid, 0);

        send(0, frame0(8'h55, 1'b0), 10, OS0);
        wait_valid(0, "fe_timeout");
        check("fe_byte", if0.rx_byte, 8'h55);
        check("fe_ferr", if0.frame_err, 1);
        check("fe_perr", if0.parity_err, 0);
        busy_seen = 1'b0;
        wait_ticks(3 * OS0);
        check("fe_no_restart", busy_seen, 0);
        consume(0);
        ser0 = 1'b1;
        wait_ticks(OS0);
        send(0, frame0(8'h9A, 1'b1), 10, OS0);
        wait_valid(0, "fe_next_timeout");
        check("fe_next_byte", if0.rx_byte, 8'h9A);
        check("fe_next_ferr", if0.frame_err, 0);
        consume(0);

        send(0, frame0(8'h11, 1'b1), 10, OS0);
        send(0, frame0(8'h22, 1'b1), 10, OS0);
        wait_ticks(2);
        check("ovr_valid", if0.rx_valid, 1);
        check("ovr_byte", if0.rx_byte, 8'h11);
        check("ovr_flag", if0.overrun, 1);
        consume(0);
        check("ovr_valid_clr", if0.rx_valid, 0);
        check("ovr_flag_clr", if0.overrun, 0);

        send(0, frame0(8'hFF, 1'b1), 4, OS0);
        check("mid_busy", busy0, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ser0 = 1'b1;
        check("mr_busy", busy0, 0);
        check("mr_byte", if0.rx_byte, 0);
        check("mr_valid", if0.rx_valid, 0);
        check("mr_ovr", if0.overrun, 0);
        check("mr_ferr", if0.frame_err, 0);
        wait_ticks(2 * OS0);
        check("mr_no_complete", if0.rx_valid, 0);
        send(0, frame0(8'h3C, 1'b1), 10, OS0);
        wait_valid(0, "mr_timeout");
        check("mr_next_byte", if0.rx_byte, 8'h3C);
        check("mr_next_ferr", if0.frame_err, 0);
        consume(0);

        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            q0.push_back('{d: d, pe: 1'b0, fe: !stp});
            send(0, frame0(d, stp), 10, OS0);
            ser0 = 1'b1;
            wait_ticks($urandom_range(OS0, 40));
        end
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            p  = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            q1.push_back('{d: d, pe: (p != (^d)), fe: !(s1 && s2)});
            send(1, frame1(d, p, s1, s2), 12, OS1);
            ser1 = 1'b1;
            wait_ticks($urandom_range(OS1, 24));
        end
        repeat (20) @(negedge clk);
        sb_en = 1'b0;
        check("sb0_left", q0.size(), 0);
        check("sb1_left", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, i_bd ticks per bit period; even, >=8.
REQ-003 Parameter PARITY_EN, default 0; 1 means a parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 i_clk  input  1  clock; all state changes on the rising edge.
REQ-007 i_reset  input  1  reset; synchronous, active-high.
REQ-008 i_rx_serial  input  1  asynchronous serial line; idle high.
REQ-009 i_bd  input  1  one-clock oversampling tick, OVERSAMPLE ticks per bit.
REQ-010 i_rx_ready  input  1  consumer accepts the held byte.
REQ-011 o_rx_byte  output  DATA_BITS  received data, LSB = first bit on the line.
REQ-012 o_rx_valid  output  1  holding register contains an unconsumed byte.
REQ-013 o_parity_err  output  1  parity mismatch on the held byte.
REQ-014 o_frame_err  output  1  a stop bit of the held byte was sampled 0.
REQ-015 o_overrun  output  1  sticky flag; a completed frame was discarded.
REQ-016 o_busy  output  1  FSM is not in IDLE.

Function
REQ-017 i_rx_serial SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: synchronized line 0 while armed -> START, with the tick counter cleared; this transition does not require i_bd.
REQ-020 START: count i_bd ticks.
- At tick count OVERSAMPLE/2-1, line 0 -> DATA, with the counter and bit index cleared.
- At the same tick, line 1 -> IDLE (false start); no output change.
REQ-021 DATA: sample the line on the i_bd tick at which the counter equals OVERSAMPLE-1.
- Shift the sample in LSB-first and clear the counter.
- After bit DATA_BITS-1 -> PARITY if PARITY_EN=1, else -> STOP.
REQ-022 PARITY: sample one bit at the same mid-bit point.
- Expected parity is the XOR of the data bits for even parity, or its inverse for odd parity.
- A mismatch sets the frame's parity error.
REQ-023 STOP: sample STOP_BITS bits at the mid-bit point; any 0 sets the frame's frame error.
REQ-024 At the last stop-bit sample the FSM SHALL return to IDLE and the frame SHALL complete.
REQ-025 On completion, o_rx_byte, o_parity_err and o_frame_err SHALL be loaded and o_rx_valid asserted on the next clock edge.
REQ-026 Handshake: o_rx_valid, o_rx_byte and the error flags SHALL hold until a cycle with o_rx_valid=1 and i_rx_ready=1; o_rx_valid then deasserts on the next edge.
REQ-027 Completion while o_rx_valid=1 and i_rx_ready=0: the new frame SHALL be discarded, the held data left unchanged, and o_overrun set.
REQ-028 Completion in the same cycle as a handshake: the new frame SHALL be loaded, o_rx_valid stays 1, and no overrun occurs.
REQ-029 o_overrun SHALL clear on the next handshake.
REQ-030 After a frame with frame error, IDLE SHALL be disarmed until the synchronized line has been 1 at one i_bd tick; this prevents break-induced restarts.
REQ-031 o_parity_err SHALL be 0 whenever PARITY_EN=0.
REQ-032 Counter widths: tick counter clog2(OVERSAMPLE), bit index clog2(DATA_BITS); neither counter wraps within a frame.

Reset
REQ-033 With i_reset=1, at the next edge:
- FSM = IDLE, armed.
- Counters = 0.
- Synchronizer flops = 1.
- o_rx_byte = 0; o_rx_valid, o_parity_err, o_frame_err, o_overrun and o_busy = 0.
REQ-034 Reset mid-frame SHALL abandon the frame with no completion; reset has priority over all other events.

Verification
REQ-035 Defaults, frame 0xA5 8N1 -> one o_rx_valid with o_rx_byte=0xA5, no error flags; valid held until i_rx_ready=1.
REQ-036 PARITY_EN=1, even parity, data 0x07 sent with parity bit 0 -> o_rx_byte=0x07, o_parity_err=1; with parity bit 1 -> o_parity_err=0.
REQ-037 Line low for 4 ticks, then high -> START entered, return to IDLE, o_rx_valid stays 0, o_busy back to 0.
REQ-038 Frame 0x55 with stop bit 0 and line held low afterwards -> o_frame_err=1; no new frame starts until the line returns high.
REQ-039 Frames 0x11 then 0x22 with i_rx_ready=0 -> held 0x11, o_overrun=1; asserting i_rx_ready clears o_overrun and o_rx_valid.
REQ-040 i_reset asserted after 3 data bits of a frame -> all outputs 0; the next frame 0x3C is received correctly.
